// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
// Holds the default word width, the output register state type and a counter-width helper.
package sipo_pkg;

  localparam int SIPO_DEF_WIDTH = 4;

  typedef enum logic {OUT_EMPTY, OUT_FULL} sipo_out_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter that assemble serial bits into words.
// Emits a one-cycle word_done together with the word that includes the completing bit.
module sipo_shift_core import sipo_pkg::*; #(
  parameter int WIDTH     = SIPO_DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      si,
  input  logic                      si_valid,
  output logic [WIDTH-1:0]          word,
  output logic                      word_done,
  output logic [cnt_w(WIDTH)-1:0]   bit_cnt
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;

  generate
    if (LSB_FIRST) begin : g_lsb
      assign shifted = {si, sh_q[WIDTH-1:1]};
    end else begin : g_msb
      assign shifted = {sh_q[WIDTH-2:0], si};
    end
  endgenerate

  // si is only looked at when si_valid is high, so an undriven si never reaches state
  always_comb begin
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    if (clr) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (si_valid) begin
      sh_d = shifted;
      if (cnt_q == LAST_IDX) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign word    = shifted;
  assign bit_cnt = cnt_q;

endmodule

// File: rtl/sipo_deser.sv
// Deserializer top: shift core plus a one-word output register with valid/ready.
// A word completing while the register is held and not being accepted is dropped and sets overrun.
module sipo_deser import sipo_pkg::*; #(
  parameter int WIDTH     = SIPO_DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      si,
  input  logic                      si_valid,
  input  logic                      clr,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      overrun,
  output logic [cnt_w(WIDTH)-1:0]   bit_cnt
);

  logic [WIDTH-1:0] word;
  logic             wordDone;

  sipo_out_state_t  state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             overrun_q, overrun_d;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .si        (si),
    .si_valid  (si_valid),
    .word      (word),
    .word_done (wordDone),
    .bit_cnt   (bit_cnt)
  );

  // wordDone is already suppressed during clr, so clearing and setting overrun never collide
  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    overrun_d = overrun_q;
    if (clr) begin
      overrun_d = 1'b0;
    end
    case (state_q)
      OUT_EMPTY: begin
        if (wordDone) begin
          dout_d  = word;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (wordDone) begin
          if (dout_ready) begin
            dout_d = word;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (dout_ready) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OUT_EMPTY;
      dout_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == OUT_FULL);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: an LSB-first and an MSB-first instance share one stimulus stream.
// A bit-queue model predicts every output each cycle; directed scenarios add literal checks.
module tb_sipo_deser;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst, clr, si, siValid, doutReady;

  logic [W-1:0] doutL, doutM;
  logic         validL, validM, ovrL, ovrM;
  logic [1:0]   cntL, cntM;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) dutL (
    .clk(clk), .rst(rst), .si(si), .si_valid(siValid), .clr(clr),
    .dout(doutL), .dout_valid(validL), .dout_ready(doutReady),
    .overrun(ovrL), .bit_cnt(cntL)
  );

  sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) dutM (
    .clk(clk), .rst(rst), .si(si), .si_valid(siValid), .clr(clr),
    .dout(doutM), .dout_valid(validM), .dout_ready(doutReady),
    .overrun(ovrM), .bit_cnt(cntM)
  );

  // Behavioural model: bits received so far, held word per ordering, flags
  bit           mBits[$];
  logic [W-1:0] mDoutL, mDoutM;
  bit           mFull, mOvr, modelLive;

  initial modelLive = 1'b0;

  always @(posedge clk) begin
    bit           done;
    logic [W-1:0] wl, wm;
    done = 1'b0;
    wl   = '0;
    wm   = '0;
    if (rst) begin
      mBits.delete();
      mDoutL    = '0;
      mDoutM    = '0;
      mFull     = 1'b0;
      mOvr      = 1'b0;
      modelLive = 1'b1;
    end else begin
      if (clr) begin
        mBits.delete();
        mOvr = 1'b0;
      end else if (siValid) begin
        mBits.push_back(si);
        if (mBits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wl[i]       = mBits[i];
            wm[W-1-i]   = mBits[i];
          end
          mBits.delete();
          done = 1'b1;
        end
      end
      if (!mFull) begin
        if (done) begin
          mDoutL = wl;
          mDoutM = wm;
          mFull  = 1'b1;
        end
      end else if (done) begin
        if (doutReady) begin
          mDoutL = wl;
          mDoutM = wm;
        end else begin
          mOvr = 1'b1;
        end
      end else if (doutReady) begin
        mFull = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("m_doutL",  doutL,  mDoutL);
      checkOutput("m_doutM",  doutM,  mDoutM);
      checkOutput("m_validL", validL, mFull);
      checkOutput("m_validM", validM, mFull);
      checkOutput("m_ovrL",   ovrL,   mOvr);
      checkOutput("m_ovrM",   ovrM,   mOvr);
      checkOutput("m_cntL",   cntL,   mBits.size());
      checkOutput("m_cntM",   cntM,   mBits.size());
    end
  end

  // Drive one cycle of inputs at negedge and return just after the sampling edge
  task automatic applyStimulus(input logic r, input logic c, input logic s,
                               input logic v, input logic rd);
    @(negedge clk);
    rst       = r;
    clr       = c;
    si        = s;
    siValid   = v;
    doutReady = rd;
    @(posedge clk);
    #1;
  endtask

  // Sends w[0] first; rdyLast is asserted only with the final bit
  task automatic sendWord(input logic [3:0] w, input logic rdyLast);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, w[i], 1'b1, (i == 3) ? rdyLast : 1'b0);
    end
  endtask

  task automatic drain();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; si = 1'b0; siValid = 1'b0; doutReady = 1'b0;

    // Initial reset
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst0_dout",  doutL,  0);
    checkOutput("rst0_valid", validL, 0);
    checkOutput("rst0_cnt",   cntL,   0);

    // Single word: bits 1,0,1,1
    sendWord(4'b1101, 1'b0);
    checkOutput("single_doutL", doutL,  4'hD);
    checkOutput("single_doutM", doutM,  4'hB);
    checkOutput("single_valid", validL, 1);
    checkOutput("single_cnt",   cntL,   0);
    drain();
    checkOutput("single_accept", validL, 0);
    checkOutput("single_stale",  doutL,  4'hD);

    // Gapped input with undriven si in gaps
    for (int i = 0; i < 4; i++) begin
      logic [3:0] gw;
      gw = 4'b1101;
      applyStimulus(1'b0, 1'b0, gw[i], 1'b1, 1'b0);
      checkOutput("gap_cnt", cntL, (i + 1) % 4);
      applyStimulus(1'b0, 1'b0, 1'bx, 1'b0, 1'b0);
      checkOutput("gap_hold", cntL, (i + 1) % 4);
    end
    checkOutput("gap_dout",  doutL,  4'hD);
    checkOutput("gap_valid", validL, 1);
    drain();

    // Overrun: 5 pending, 3 completes without ready
    sendWord(4'h5, 1'b0);
    sendWord(4'h3, 1'b0);
    checkOutput("ovr_dout",  doutL, 4'h5);
    checkOutput("ovr_doutM", doutM, 4'hA);
    checkOutput("ovr_flag",  ovrL,  1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("clr_ovr",   ovrL,   0);
    checkOutput("clr_valid", validL, 1);
    checkOutput("clr_cnt",   cntL,   0);
    drain();

    // Accept and complete on the same edge
    sendWord(4'hA, 1'b0);
    sendWord(4'h6, 1'b1);
    checkOutput("sim_dout",  doutL,  4'h6);
    checkOutput("sim_valid", validL, 1);
    checkOutput("sim_ovr",   ovrL,   0);
    drain();

    // Resync after two bits, then 0,1,1,0
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("resync_cnt", cntM, 0);
    sendWord(4'b0110, 1'b0);
    checkOutput("resync_doutM", doutM, 4'h6);
    checkOutput("resync_doutL", doutL, 4'h6);

    // Reset mid-word with a pending word
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_dout",  doutL,  0);
    checkOutput("rst_valid", validL, 0);
    checkOutput("rst_ovr",   ovrL,   0);
    checkOutput("rst_cnt",   cntL,   0);

    // Back-to-back words with ready held high
    for (int i = 0; i < 8; i++) begin
      logic [7:0] bb;
      bb = 8'hE9;
      applyStimulus(1'b0, 1'b0, bb[i], 1'b1, 1'b1);
      if (i == 3) checkOutput("b2b_first", doutL, 4'h9);
    end
    checkOutput("b2b_second", doutL,  4'hE);
    checkOutput("b2b_valid",  validL, 1);
    checkOutput("b2b_ovr",    ovrL,   0);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 19) == 0), 1'($urandom),
                    1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in, parallel-out deserializer that consumes the 1-bit serial stream of the team's parallel-in/serial-out shift stage and rebuilds WIDTH-bit words.
- Each incoming bit is qualified by si_valid.
- Completed words are held in an output register with a valid/ready handshake.
- Words that complete while the output register is still occupied are dropped and flagged as overrun.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = first received bit lands in dout[0]; this matches the serializer, which shifts its bit 0 out first. 0 = first received bit lands in dout[WIDTH-1].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- si  input  1  serial data bit
- si_valid  input  1  si is sampled only on clock edges where si_valid=1
- clr  input  1  synchronous frame resync; discards the partial word and clears overrun
- dout  output  WIDTH  assembled word, held until accepted
- dout_valid  output  1  dout holds an unaccepted word
- dout_ready  input  1  consumer accepts dout on an edge where dout_valid=1 and dout_ready=1
- overrun  output  1  sticky flag: a completed word was dropped
- bit_cnt  output  $clog2(WIDTH)  number of bits collected in the current partial word

Behaviour:
- All state is registered on posedge clk. Priority order: rst, then clr, then normal operation.
- Reset values: dout=0, dout_valid=0, overrun=0, bit_cnt=0, internal shift register=0.
- Shift, when si_valid=1:
  - LSB_FIRST=1: sh <= {si, sh[WIDTH-1:1]}.
  - LSB_FIRST=0: sh <= {sh[WIDTH-2:0], si}.
  - bit_cnt increments by 1.
- When si_valid=0: sh and bit_cnt hold. The value of si is don't-care, and X on si must not propagate.
- Word completion = si_valid=1 while bit_cnt==WIDTH-1.
  - On that same edge bit_cnt wraps to 0.
  - The assembled word (including the current bit) is the load candidate for dout.
  - Latency: dout and dout_valid are visible immediately after the edge that samples the final bit, i.e. 0 extra cycles.
- Output register, two states: EMPTY (dout_valid=0) and FULL (dout_valid=1).
  - EMPTY + completion -> load dout, go to FULL.
  - FULL + dout_ready, no completion -> go to EMPTY; dout keeps its stale value.
  - FULL + dout_ready + completion on the same edge -> load the new word, stay FULL, no overrun.
  - FULL + no dout_ready + completion -> new word dropped, dout unchanged, overrun <= 1.
  - dout_ready while EMPTY is ignored.
- overrun stays set until rst or clr.
- clr:
  - Effects: bit_cnt=0, sh=0, overrun=0.
  - Does not affect dout or dout_valid; a pending word survives resync.
  - A bit presented with si_valid in the same cycle as clr is discarded.
  - dout_ready is still honoured in a clr cycle.
- rst mid-word or with dout_valid=1: everything returns to reset values and the pending word is lost.
- Back-to-back words: completion on consecutive word boundaries with si_valid held high continuously is legal and needs no gap cycles.

Decomposition:
- Shared package sipo_pkg:
  - SIPO_DEF_WIDTH=4.
  - typedef enum logic {OUT_EMPTY, OUT_FULL} sipo_out_state_t.
  - Function cnt_w(width) returning $clog2(width).
- One sub-module, sipo_shift_core:
  - Contains the shift register, the bit counter and the completion pulse.
  - Ports: clk, rst, clr, si, si_valid, word, word_done, bit_cnt.
- Top level sipo_deser adds the output holding register, the handshake FSM and overrun.

Test Plan (all scenarios use WIDTH=4, LSB_FIRST=1 unless noted):
- Reset: assert rst for 2 cycles mid-word with dout_valid=1 -> dout=0, dout_valid=0, overrun=0, bit_cnt=0 on the next edge.
- Single word: bits 1,0,1,1 on consecutive si_valid cycles, dout_ready=0 -> dout=4'hD, dout_valid=1 right after the 4th edge. Assert dout_ready for one cycle -> dout_valid=0.
- Gapped input: same bits with si_valid=0 and si=X gap cycles between them -> dout=4'hD, bit_cnt steps 0,1,2,3,0, no X on any output.
- Overrun: word 4'h5 with no ready, then 4'h3 completes -> dout stays 4'h5, overrun=1. Then clr -> overrun=0, dout_valid still 1.
- Simultaneous accept and complete: dout=4'hA pending, dout_ready=1 on the edge completing 4'h6 -> dout=4'h6, dout_valid=1, overrun=0.
- LSB_FIRST=0 variant: bits 1,0,1,1 -> dout=4'hB. Also clr after 2 bits, then bits 0,1,1,0 -> dout=4'h6.
